// File: rtl/nios_mul_arb_pkg.sv
// Shared constants, types and helpers for the multiplier-cell arbiter.
package nios_mul_arb_pkg;

  localparam int OPND_W    = 32;
  localparam int MAX_REQ   = 8;
  localparam int MAX_IDX_W = 3;

  // Index width for a requester count; a single requester still gets one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Tag travelling alongside the operands through the cell.
  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/nios_mul_rr_pick.sv
// Combinational round-robin picker: first eligible index after ptr, modulo N.
module nios_mul_rr_pick
  import nios_mul_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
)
(
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  always_comb begin
    int            cand;
    logic [IW-1:0] cand_idx;
    cand      = 0;
    cand_idx  = '0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    // Offset N wraps back to ptr itself, so the last-served requester is checked last.
    for (int off = 1; off <= N; off++) begin
      cand     = (int'(ptr) + off) % N;
      cand_idx = IW'(cand);
      if (!grant_any && eligible[cand_idx]) begin
        grant_any       = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/nios_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined 32x32 low-word multiplier between requesters.
// Optional NIOS_MUL_ARB_PRIO0_EN: requester 0 gets absolute priority, 1..NUM_REQ-1 rotate.
module nios_mul_arbiter
  import nios_mul_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int CELL_LAT = 1
)
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [OPND_W*NUM_REQ-1:0] req_src1,
  input  logic [OPND_W*NUM_REQ-1:0] req_src2,
  output logic [NUM_REQ-1:0]        ack,
  output logic [OPND_W-1:0]         mult_src1,
  output logic [OPND_W-1:0]         mult_src2,
  input  logic [OPND_W-1:0]         cell_result,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [OPND_W-1:0]         rsp_data,
  output logic                      busy
);

  localparam int IW    = idx_w(NUM_REQ);
  localparam int DEPTH = 1 + CELL_LAT;

  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] pending_next;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] pick_elig;
  logic [NUM_REQ-1:0] pick_grant;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] rsp_hot;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      pick_idx;
  logic [IW-1:0]      win_idx;
  logic               pick_any;
  logic               win_any;
  logic [OPND_W-1:0]  sel_src1;
  logic [OPND_W-1:0]  sel_src2;
  tag_t               tag_pipe [DEPTH];
  tag_t               tail;

  // Issue handshake: requester i is accepted in a cycle where req[i] && ack[i];
  // it must hold req and its operands stable until then. Responses have no backpressure.
  assign eligible = req & ~pending;

`ifdef NIOS_MUL_ARB_PRIO0_EN
  assign pick_elig = eligible & ~NUM_REQ'(1);
`else
  assign pick_elig = eligible;
`endif

  nios_mul_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .eligible  (pick_elig),
    .ptr       (ptr),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .grant_any (pick_any)
  );

  always_comb begin
    grant   = pick_grant;
    win_idx = pick_idx;
    win_any = pick_any;
`ifdef NIOS_MUL_ARB_PRIO0_EN
    if (eligible[0]) begin
      grant   = NUM_REQ'(1);
      win_idx = '0;
      win_any = 1'b1;
    end
`endif
    // Nothing is accepted while reset is held.
    if (!reset_n) begin
      grant   = '0;
      win_any = 1'b0;
    end
  end

  assign ack = grant;

  always_comb begin
    sel_src1 = '0;
    sel_src2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_src1 = req_src1[i*OPND_W +: OPND_W];
        sel_src2 = req_src2[i*OPND_W +: OPND_W];
      end
    end
  end

  assign tail = tag_pipe[DEPTH-1];

  always_comb begin
    rsp_hot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_hot[i] = tail.valid && (int'(tail.idx) == i);
    end
  end

  // A tail tag and a new grant can never hit the same requester: the tail one is pending.
  assign pending_next = (pending & ~rsp_hot) | grant;

  always_comb begin
    busy = |rsp_valid;
    for (int s = 0; s < DEPTH; s++) begin
      busy = busy | tag_pipe[s].valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending   <= '0;
      ptr       <= IW'(NUM_REQ - 1);
      mult_src1 <= '0;
      mult_src2 <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        tag_pipe[s] <= '0;
      end
    end else begin
      pending <= pending_next;
      tag_pipe[0].valid <= win_any;
      tag_pipe[0].idx   <= win_any ? MAX_IDX_W'(win_idx) : '0;
      for (int s = 1; s < DEPTH; s++) begin
        tag_pipe[s] <= tag_pipe[s-1];
      end
      if (win_any) begin
        mult_src1 <= sel_src1;
        mult_src2 <= sel_src2;
`ifdef NIOS_MUL_ARB_PRIO0_EN
        if (win_idx != '0) begin
          ptr <= win_idx;
        end
`else
        ptr <= win_idx;
`endif
      end
      rsp_valid <= rsp_hot;
      if (tail.valid) begin
        rsp_data <= cell_result;
      end
    end
  end

endmodule

// File: tb/tb_nios_mul_arbiter.sv
// Self-checking bench for nios_mul_arbiter: directed steps then randomized traffic vs a reference model.
module tb_nios_mul_arbiter;

  localparam int N = 4;
  localparam int L = 1;
  localparam int W = 32;
`ifdef NIOS_MUL_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  logic           clk      = 1'b0;
  logic           reset_n  = 1'b0;
  logic [N-1:0]   req      = '0;
  logic [W*N-1:0] req_src1 = '0;
  logic [W*N-1:0] req_src2 = '0;
  logic [N-1:0]   ack;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   mult_src1;
  logic [W-1:0]   mult_src2;
  logic [W-1:0]   cell_result;
  logic [W-1:0]   rsp_data;
  logic           busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // clock / reset block
  always #5 clk = ~clk;

  nios_mul_arbiter #(
    .NUM_REQ  (N),
    .CELL_LAT (L)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .req_src1    (req_src1),
    .req_src2    (req_src2),
    .ack         (ack),
    .mult_src1   (mult_src1),
    .mult_src2   (mult_src2),
    .cell_result (cell_result),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .busy        (busy)
  );

  // Behavioural multiplier cell with L cycles of latency.
  logic [W-1:0] cell_pipe [L];
  always @(posedge clk) begin
    cell_pipe[0] <= mult_src1 * mult_src2;
    for (int k = 1; k < L; k++) cell_pipe[k] <= cell_pipe[k-1];
  end
  assign cell_result = cell_pipe[L-1];

  // Reference model: pending set, pointer, and expected responses in issue order.
  typedef struct {
    int           idx;
    logic [W-1:0] prod;
    int           due;
  } rsp_t;

  rsp_t         exp_q[$];
  logic [N-1:0] m_pend = '0;
  int           m_ptr  = N - 1;
  logic [N-1:0] m_acc  = '0;
  logic [N-1:0] keep   = '0;
  logic [W-1:0] last_rsp [N];

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic int model_winner(input logic [N-1:0] elig);
    int w;
    w = -1;
    if (PRIO0 && elig[0]) return 0;
    for (int off = 1; off <= N; off++) begin
      int c;
      c = (m_ptr + off) % N;
      if (PRIO0 && c == 0) continue;
      if (w < 0 && elig[c]) w = c;
    end
    return w;
  endfunction

  task automatic model_step();
    logic [N-1:0] elig;
    logic [N-1:0] exp_ack;
    logic [N-1:0] exp_rv;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] p;
    int           win;
    exp_ack = '0;
    exp_rv  = '0;
    win     = -1;
    foreach (exp_q[k]) if (exp_q[k].due == cyc) m_pend[exp_q[k].idx] = 1'b0;
    elig = req & ~m_pend;
    if (reset_n) win = model_winner(elig);
    if (win >= 0) exp_ack[win] = 1'b1;
    check_eq("ack", W'(ack), W'(exp_ack));
    check_eq("busy", W'(busy), W'(exp_q.size() != 0));
    if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
      exp_rv[exp_q[0].idx] = 1'b1;
      check_eq("rsp_valid", W'(rsp_valid), W'(exp_rv));
      check_eq("rsp_data", rsp_data, exp_q[0].prod);
      last_rsp[exp_q[0].idx] = rsp_data;
      void'(exp_q.pop_front());
    end else begin
      check_eq("rsp_valid", W'(rsp_valid), W'(exp_rv));
    end
    m_acc = exp_ack;
    if (!reset_n) begin
      exp_q.delete();
      m_pend = '0;
      m_ptr  = N - 1;
      m_acc  = '0;
    end else if (win >= 0) begin
      a = req_src1[win*W +: W];
      b = req_src2[win*W +: W];
      p = a * b;
      m_pend[win] = 1'b1;
      if (!(PRIO0 && win == 0)) m_ptr = win;
      exp_q.push_back('{idx: win, prod: p, due: cyc + 2 + L});
    end
  endtask

  // driver tasks
  task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_src1[i*W +: W] = a;
    req_src2[i*W +: W] = b;
    req[i] = 1'b1;
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (m_acc[i]) begin
        if (keep[i]) issue(i, W'($urandom), W'($urandom));
        else req[i] = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic check_reset_state();
    check_eq("rst_mult_src1", mult_src1, '0);
    check_eq("rst_mult_src2", mult_src2, '0);
    check_eq("rst_rsp_data", rsp_data, '0);
    check_eq("rst_rsp_valid", W'(rsp_valid), '0);
    check_eq("rst_busy", W'(busy), '0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    check_reset_state();
  endtask

  initial begin
    for (int i = 0; i < N; i++) last_rsp[i] = 'x;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_reset_state();

    // 7 x 6 from requester 0: ack immediately, response three cycles later
    issue(0, 32'd7, 32'd6);
    repeat (5) cycle();
    check_eq("t1_product", last_rsp[0], 32'd42);

    // all requesters held continuously
    do_reset();
    keep = '1;
    for (int i = 0; i < N; i++) issue(i, W'($urandom), W'($urandom));
    repeat (24) cycle();
    keep = '0;
    repeat (12) cycle();

    // wrap-around products
    last_rsp[0] = 'x;
    last_rsp[1] = 'x;
    issue(0, 32'hFFFF_FFFF, 32'h0000_0002);
    issue(1, 32'h0001_0000, 32'h0001_0000);
    repeat (8) cycle();
    check_eq("t3_wrap", last_rsp[0], 32'hFFFF_FFFE);
    check_eq("t3_zero", last_rsp[1], 32'h0000_0000);

    // reset one cycle after an accept discards it
    do_reset();
    issue(0, 32'd3, 32'd5);
    cycle();
    req = '0;
    do_reset();
    last_rsp[2] = 'x;
    issue(2, 32'd9, 32'd11);
    repeat (7) cycle();
    check_eq("t4_after_reset", last_rsp[2], 32'd99);

    // requester 1 pulses for one cycle while 0 is granted
    do_reset();
    issue(0, 32'd12, 32'd12);
    issue(1, 32'd13, 32'd13);
    cycle();
    req[1] = 1'b0;
    repeat (5) cycle();
    last_rsp[1] = 'x;
    issue(1, 32'd4, 32'd4);
    repeat (5) cycle();
    check_eq("t6_late_req1", last_rsp[1], 32'd16);

    // randomized traffic with occasional abandoned requests and resets
    repeat (400) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 1) == 1) issue(i, rnd_op(), rnd_op());
        end else if ($urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
      end
      if ($urandom_range(0, 149) == 0) do_reset();
      else cycle();
    end
    req = '0;
    repeat (8) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
